// File: rtl/fetch_buffer.sv
// Instruction queue between the ibus response and decode: credit-based issue
// control, in-order FIFO of {pc, instr}, and discard of stale responses after a flush.
// Optional same-cycle bypass into an empty queue: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_fire,
  input  logic                  rsp_valid,
  input  logic [31:0]           rsp_pc,
  input  logic [31:0]           rsp_instr,
  output logic                  issue_ok,
  output logic                  deq_valid,
  output logic [31:0]           deq_pc,
  output logic [31:0]           deq_instr,
  input  logic                  deq_ready,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   count
);

  // Handshake: an entry moves to decode on a cycle where deq_valid && deq_ready
  // and flush is low; fetch may only fire a request while issue_ok is high.

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];

  ptr_t head, tail;
  cnt_t count_q, outstanding, discard;

  logic empty, full, rsp_live, accept, drop_stale;
  logic bypass_hit, bypass_take, enq, deq, rsp_retire;
  cnt_t outstanding_next;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == cnt_t'(DEPTH));
    rsp_live   = rsp_valid && !flush;
    accept     = rsp_live && (discard == '0);
    drop_stale = rsp_live && (discard != '0);
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass_hit  = accept && empty;
    bypass_take = bypass_hit && deq_ready;
`else
    bypass_hit  = 1'b0;
    bypass_take = 1'b0;
`endif
    // A full queue drops the response; issue_ok is meant to make this unreachable.
    enq        = accept && !full && !bypass_take;
    deq        = !empty && deq_ready && !flush;
    rsp_retire = rsp_valid && (outstanding != '0);
    outstanding_next = outstanding + cnt_t'(req_fire) - cnt_t'(rsp_retire);
  end

  always_comb begin
    issue_ok  = ({1'b0, count_q} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
    deq_valid = !empty || bypass_hit;
    deq_pc    = '0;
    deq_instr = '0;
    if (!empty) begin
      deq_pc    = mem_pc[head];
      deq_instr = mem_instr[head];
    end else if (bypass_hit) begin
      deq_pc    = rsp_pc;
      deq_instr = rsp_instr;
    end
  end

  assign count = count_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[tail]    <= rsp_pc;
      mem_instr[tail] <= rsp_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (flush) begin
        // Every response still owed after this cycle belongs to the old path.
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
        discard <= outstanding_next;
      end else begin
        if (enq)        tail    <= tail + PTR_ONE;
        if (deq)        head    <= head + PTR_ONE;
        if (drop_stale) discard <= discard - CNT_ONE;
        count_q <= count_q + cnt_t'(enq) - cnt_t'(deq);
      end
    end
  end

  a_rsp_owed: assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (accept && !bypass_take) |-> !full);

endmodule
